// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/branch controller and sole owner of the PC control lines.
// Fetches one instruction at a time (fetch_req/fetch_ack), captures its op
// class, target and condition, then issues at most one PC pulse
// (pc_inc / pc_jump / pc_reset) per instruction. A DEPTH-entry LIFO holds
// return addresses for CALL/RET; overflow or underflow parks the block in
// a sticky ERROR state that only reset leaves.
// Ports:
//   clk, reset (sync, active high), start
//   pc_q                       current PC value
//   fetch_ack, op, target, cond instruction memory response
//   pc_inc, pc_jump, pc_reset, pc_data  PC register controls
//   fetch_req                  instruction fetch request
//   busy, halted, stack_err    status
// All outputs decode from state and captured registers only (Moore).
module pc_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pc_q,
  input  logic             fetch_ack,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic             cond,
  output logic             pc_inc,
  output logic             pc_jump,
  output logic             pc_reset,
  output logic [WIDTH-1:0] pc_data,
  output logic             fetch_req,
  output logic             busy,
  output logic             halted,
  output logic             stack_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_JMP   = 3'd1;
  localparam logic [2:0] OP_JCOND = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_HALT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET_PC, S_FETCH, S_EXEC, S_HALT, S_ERROR
  } state_t;

  state_t           state, nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] tgt_r;
  logic             cond_r;

  // sp counts valid entries (0..DEPTH), so it needs one bit more than the index
  logic [AW:0]      sp, sp_m1;
  logic [WIDTH-1:0] stk [DEPTH];
  logic             full, empty, do_push, do_pop;

  assign sp_m1   = sp - 1'b1;
  assign full    = (sp == (AW+1)'(DEPTH));
  assign empty   = (sp == '0);
  assign do_push = (state == S_EXEC) && (op_r == OP_CALL) && !full;
  assign do_pop  = (state == S_EXEC) && (op_r == OP_RET) && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      sp     <= '0;
      op_r   <= '0;
      tgt_r  <= '0;
      cond_r <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_RESET_PC) sp <= '0;
      else if (do_push)        sp <= sp + 1'b1;
      else if (do_pop)         sp <= sp_m1;
      if (state == S_FETCH && fetch_ack) begin
        op_r   <= op;
        tgt_r  <= target;
        cond_r <= cond;
      end
    end
  end

  // Return address is the calling instruction's address + 1, wrapping at 2^WIDTH
  always_ff @(posedge clk) begin
    if (!reset && do_push) stk[sp[AW-1:0]] <= pc_q + 1'b1;
  end

  always_comb begin
    nxt       = state;
    pc_inc    = 1'b0;
    pc_jump   = 1'b0;
    pc_reset  = 1'b0;
    pc_data   = '0;
    fetch_req = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    stack_err = 1'b0;
    case (state)
      S_IDLE: if (start) nxt = S_RESET_PC;
      S_RESET_PC: begin
        busy     = 1'b1;
        pc_reset = 1'b1;
        nxt      = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        fetch_req = 1'b1;
        if (fetch_ack) nxt = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        nxt  = S_FETCH;
        case (op_r)
          OP_JMP: begin
            pc_jump = 1'b1;
            pc_data = tgt_r;
          end
          OP_JCOND: begin
            if (cond_r) begin
              pc_jump = 1'b1;
              pc_data = tgt_r;
            end else begin
              pc_inc = 1'b1;
            end
          end
          OP_CALL: begin
            if (full) nxt = S_ERROR;
            else begin
              pc_jump = 1'b1;
              pc_data = tgt_r;
            end
          end
          OP_RET: begin
            if (empty) nxt = S_ERROR;
            else begin
              pc_jump = 1'b1;
              pc_data = stk[sp_m1[AW-1:0]];
            end
          end
          OP_HALT: nxt = S_HALT;
          default: pc_inc = 1'b1;  // SEQ and reserved op classes
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) nxt = S_RESET_PC;
      end
      S_ERROR: begin
        halted    = 1'b1;
        stack_err = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset, start, fetch_ack, cond;
  logic [2:0]    op;
  logic [W-1:0]  target;
  logic [W-1:0]  pc_q = 16'h1234;
  logic          pc_inc, pc_jump, pc_reset, fetch_req, busy, halted, stack_err;
  logic [W-1:0]  pc_data;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_q(pc_q),
    .fetch_ack(fetch_ack), .op(op), .target(target), .cond(cond),
    .pc_inc(pc_inc), .pc_jump(pc_jump), .pc_reset(pc_reset), .pc_data(pc_data),
    .fetch_req(fetch_req), .busy(busy), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // PC register being controlled
  always @(posedge clk) begin
    if (pc_reset)     pc_q <= '0;
    else if (pc_jump) pc_q <= pc_data;
    else if (pc_inc)  pc_q <= pc_q + 1'b1;
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] tgt;
    logic         cnd;
    int           waits;
    logic         ei, ej;
    logic [W-1:0] ed, ep;
    logic         eh, ee;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, " outs"}, {29'd0, pc_inc, pc_jump, pc_reset}, 0);
    chk({name, " stat"}, {28'd0, fetch_req, busy, halted, stack_err}, 0);
    chk({name, " data"}, {16'd0, pc_data}, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start pc_reset", {30'd0, pc_reset, busy}, 32'b11);
    chk("start no fetch", {31'd0, fetch_req}, 0);
    tick();
    chk("fetch after reset", {30'd0, fetch_req, pc_reset}, 32'b10);
    chk("pc cleared", {16'd0, pc_q}, 0);
  endtask

  // Entered just after an edge with the DUT in FETCH
  task automatic do_instr(input logic [2:0] o, input logic [W-1:0] t, input logic c,
                          input int waits, input logic ei, input logic ej,
                          input logic [W-1:0] ed, input logic [W-1:0] ep,
                          input logic eh, input logic ee);
    for (int w = 0; w < waits; w++) begin
      chk("wait fetch_req", {31'd0, fetch_req}, 1);
      chk("wait no pulse", {29'd0, pc_inc, pc_jump, pc_reset}, 0);
      tick();
    end
    op = o; target = t; cond = c; fetch_ack = 1'b1;
    chk("fetch_req before ack", {31'd0, fetch_req}, 1);
    tick();
    // scramble inputs: EXEC must act on captured values
    fetch_ack = 1'b0; op = 3'd5; target = ~t; cond = ~c;
    chk("exec pulse", {28'd0, pc_inc, pc_jump, pc_reset, fetch_req}, {28'd0, ei, ej, 2'b00});
    if (ej) chk("exec pc_data", {16'd0, pc_data}, {16'd0, ed});
    tick();
    op = 3'd0;
    chk("pc after", {16'd0, pc_q}, {16'd0, ep});
    chk("status after", {28'd0, fetch_req, busy, halted, stack_err},
        {28'd0, !eh, !eh, eh, ee});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; fetch_ack = 1'b0; op = '0; target = '0; cond = 1'b0;
    //        op    tgt       c  w  inc jmp data      pc_after  h  e
    tv[0]  = '{3'd0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h0001, 0, 0};
    tv[1]  = '{3'd0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h0002, 0, 0};
    tv[2]  = '{3'd0, 16'h0000, 0, 2, 1, 0, 16'h0000, 16'h0003, 0, 0};
    tv[3]  = '{3'd7, 16'h0777, 1, 0, 1, 0, 16'h0000, 16'h0004, 0, 0};
    tv[4]  = '{3'd1, 16'd1997, 0, 0, 0, 1, 16'd1997, 16'd1997, 0, 0};
    tv[5]  = '{3'd2, 16'h0100, 1, 0, 0, 1, 16'h0100, 16'h0100, 0, 0};
    tv[6]  = '{3'd2, 16'h0200, 0, 1, 1, 0, 16'h0000, 16'h0101, 0, 0};
    tv[7]  = '{3'd1, 16'h0010, 0, 0, 0, 1, 16'h0010, 16'h0010, 0, 0};
    tv[8]  = '{3'd3, 16'h0400, 0, 0, 0, 1, 16'h0400, 16'h0400, 0, 0};
    tv[9]  = '{3'd4, 16'h0999, 0, 0, 0, 1, 16'h0011, 16'h0011, 0, 0};
    tv[10] = '{3'd1, 16'hFFFF, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0};
    tv[11] = '{3'd3, 16'h0050, 0, 0, 0, 1, 16'h0050, 16'h0050, 0, 0};
    tv[12] = '{3'd4, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0};
    tv[13] = '{3'd6, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h0001, 0, 0};
    tv[14] = '{3'd5, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0};

    tick(); tick();
    chk_idle("reset");
    reset = 1'b0;
    tick();
    chk_idle("idle hold");
    do_start();

    for (int i = 0; i < 15; i++)
      do_instr(tv[i].op, tv[i].tgt, tv[i].cnd, tv[i].waits, tv[i].ei, tv[i].ej,
               tv[i].ed, tv[i].ep, tv[i].eh, tv[i].ee);

    // restart from HALT; start ignored while fetching; nested LIFO order
    do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start ignored in fetch", {30'd0, fetch_req, pc_reset}, 32'b10);
    do_instr(3'd3, 16'h0100, 0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0);
    do_instr(3'd3, 16'h0200, 0, 0, 0, 1, 16'h0200, 16'h0200, 0, 0);
    do_instr(3'd4, 16'h0000, 0, 0, 0, 1, 16'h0101, 16'h0101, 0, 0);
    do_instr(3'd4, 16'h0000, 0, 0, 0, 1, 16'h0001, 16'h0001, 0, 0);

    // overflow: DEPTH calls fill the stack, the next one faults
    for (int i = 1; i <= D; i++)
      do_instr(3'd3, 16'(i * 16'h0100), 0, 0, 0, 1, 16'(i * 16'h0100), 16'(i * 16'h0100), 0, 0);
    do_instr(3'd3, 16'h0F00, 0, 0, 0, 0, 16'h0000, 16'(D * 16'h0100), 1, 1);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("error sticky", {29'd0, stack_err, halted, busy}, 32'b110);
    chk("error no restart", {29'd0, pc_reset, fetch_req, pc_inc}, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("reset from error");

    // underflow
    do_start();
    do_instr(3'd4, 16'h0123, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1);

    // reset while in FETCH with ack pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_start();
    do_instr(3'd0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h0001, 0, 0);
    op = 3'd1; target = 16'h0AAA; fetch_ack = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("mid-fetch reset");
    tick();
    fetch_ack = 1'b0;
    chk_idle("mid-fetch reset hold");
    chk("pc untouched", {16'd0, pc_q}, 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
